// File: rtl/fxp_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
// Holds the FSM state enum, rounding-mode codes and saturation limits.
package fxp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ROUND,
    FIN,
    OUT
  } state_e;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Saturation pattern; read as unsigned it is also the overflow limit.
  function automatic logic [63:0] sat_val(
    input int   w,
    input logic sgn,
    input logic neg
  );
    if (!sgn) return (64'd1 << w) - 64'd1;
    if (neg)  return 64'd1 << (w - 1);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/fxp_div_pipe_if.sv
// Operand/result handshake bundle for fxp_div_pipe.
// master drives operands and out_ready; slave is the divider.
interface fxp_div_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             rnd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             dbz;
  logic             ovf;

  modport master (
    output in_valid, a, b, sgn, rnd, out_ready,
    input  in_ready, out_valid, q, dbz, ovf
  );

  modport slave (
    input  in_valid, a, b, sgn, rnd, out_ready,
    output in_ready, out_valid, q, dbz, ovf
  );
endinterface

// File: rtl/fxp_div_step.sv
// Combinational restoring-division slice, STEPS bits deep.
// Consumes dividend bits MSB first and emits one quotient bit per bit.
module fxp_div_step #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic [WIDTH:0]   acc,
  input  logic [STEPS-1:0] din,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH:0]   acc_nxt,
  output logic [STEPS-1:0] qbits
);

  logic [WIDTH:0] r;

  always_comb begin
    r     = acc;
    qbits = '0;
    for (int i = STEPS - 1; i >= 0; i--) begin
      r = {r[WIDTH-1:0], din[i]};
      if (r >= {1'b0, div}) begin
        r        = r - {1'b0, div};
        qbits[i] = 1'b1;
      end
    end
    acc_nxt = r;
  end

endmodule

// File: rtl/fxp_div_pipe.sv
// Sequential fixed-point divider q = a*2^FBITS/b, STEPS bits per clock.
// Truncate or round-half-even, with saturation on overflow or b==0.
module fxp_div_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 29,
  parameter int STEPS    = 1,
  parameter bit SATURATE = 1'b1
) (
  input logic          clk,
  input logic          rst,
  fxp_div_pipe_if.slave io
);

  localparam int NB = WIDTH + FBITS + 1;
  localparam int N  = NB / STEPS;
  localparam int CW = $clog2(N) + 1;
  localparam int XW = (NB > 64) ? NB : 64;

  if ((NB % STEPS) != 0) begin : g_bad_steps
    $error("fxp_div_pipe: STEPS must divide WIDTH+FBITS+1");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [NB-1:0]    dvd_q, dvd_d;
  logic [NB-1:0]    quo_q, quo_d;
  logic [NB-1:0]    mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic             rnd_q, rnd_d;
  logic             zb_q, zb_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_acc;
  logic [STEPS-1:0] step_q;
  logic [WIDTH-1:0] amag, bmag, satv;
  logic [63:0]      lim;

  fxp_div_step #(
    .WIDTH(WIDTH),
    .STEPS(STEPS)
  ) u_step (
    .acc    (acc_q),
    .din    (dvd_q[NB-1 -: STEPS]),
    .div    (div_q),
    .acc_nxt(step_acc),
    .qbits  (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    div_d       = div_q;
    dvd_d       = dvd_q;
    quo_d       = quo_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    sgn_d       = sgn_q;
    rnd_d       = rnd_q;
    zb_d        = zb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    amag        = (io.sgn && io.a[WIDTH-1]) ? -io.a : io.a;
    bmag        = (io.sgn && io.b[WIDTH-1]) ? -io.b : io.b;
    lim         = sat_val(WIDTH, sgn_q, neg_q);
    satv        = lim[WIDTH-1:0];

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          div_d      = bmag;
          dvd_d      = {amag, {(FBITS+1){1'b0}}};
          neg_d      = io.sgn & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
          sgn_d      = io.sgn;
          rnd_d      = io.rnd;
          zb_d       = (io.b == '0);
          acc_d      = '0;
          cnt_d      = '0;
          quo_d      = '0;
          in_ready_d = 1'b0;
          state_d    = (io.b == '0) ? FIN : CALC;
        end
      end
      CALC: begin
        acc_d = step_acc;
        quo_d = (quo_q << STEPS) | NB'(step_q);
        dvd_d = dvd_q << STEPS;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = ROUND;
      end
      ROUND: begin
        mag_d = quo_q >> 1;
        // quo_q[0] is the half bit; ties go to the even magnitude
        if (rnd_q == RND_RNE && quo_q[0] && (quo_q[1] || acc_q != '0))
          mag_d = (quo_q >> 1) + NB'(1);
        state_d = FIN;
      end
      FIN: begin
        dbz_d = zb_q;
        ovf_d = 1'b0;
        if (zb_q) begin
          q_d = SATURATE ? satv : '0;
        end else if (XW'(mag_q) > XW'(lim)) begin
          ovf_d = 1'b1;
          q_d   = SATURATE ? satv : '0;
        end else begin
          q_d = neg_q ? -mag_q[WIDTH-1:0] : mag_q[WIDTH-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      div_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      sgn_q       <= 1'b0;
      rnd_q       <= 1'b0;
      zb_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      div_q       <= div_d;
      dvd_q       <= dvd_d;
      quo_q       <= quo_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      sgn_q       <= sgn_d;
      rnd_q       <= rnd_d;
      zb_q        <= zb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.q         = q_q;
  assign io.dbz       = dbz_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_fxp_div_pipe.sv
// Directed + scoreboard bench for fxp_div_pipe.
// Three instances: default, SATURATE=0, and STEPS=2.
module tb_fxp_div_pipe;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [2:0]  iv  = '0;
  logic [2:0]  orv = '0;
  logic [2:0]  sv  = '0;
  logic [2:0]  rv  = '0;
  logic [31:0] av[3];
  logic [31:0] bv[3];
  logic [2:0]  ov, ir, dz, of;
  logic [31:0] qv[3];

  fxp_div_pipe_if #(.WIDTH(32)) i0 ();
  fxp_div_pipe_if #(.WIDTH(32)) i1 ();
  fxp_div_pipe_if #(.WIDTH(32)) i2 ();

  fxp_div_pipe #(.WIDTH(32), .FBITS(29), .STEPS(1), .SATURATE(1'b1))
    u0 (.clk(clk), .rst(rst), .io(i0.slave));
  fxp_div_pipe #(.WIDTH(32), .FBITS(29), .STEPS(1), .SATURATE(1'b0))
    u1 (.clk(clk), .rst(rst), .io(i1.slave));
  fxp_div_pipe #(.WIDTH(32), .FBITS(29), .STEPS(2), .SATURATE(1'b1))
    u2 (.clk(clk), .rst(rst), .io(i2.slave));

  assign i0.in_valid = iv[0];  assign i1.in_valid = iv[1];  assign i2.in_valid = iv[2];
  assign i0.out_ready = orv[0]; assign i1.out_ready = orv[1]; assign i2.out_ready = orv[2];
  assign i0.sgn = sv[0];  assign i1.sgn = sv[1];  assign i2.sgn = sv[2];
  assign i0.rnd = rv[0];  assign i1.rnd = rv[1];  assign i2.rnd = rv[2];
  assign i0.a = av[0];  assign i1.a = av[1];  assign i2.a = av[2];
  assign i0.b = bv[0];  assign i1.b = bv[1];  assign i2.b = bv[2];
  assign ov = {i2.out_valid, i1.out_valid, i0.out_valid};
  assign ir = {i2.in_ready, i1.in_ready, i0.in_ready};
  assign dz = {i2.dbz, i1.dbz, i0.dbz};
  assign of = {i2.ovf, i1.ovf, i0.ovf};
  assign qv[0] = i0.q;  assign qv[1] = i1.q;  assign qv[2] = i2.q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: direct wide division, rounding on 2*remainder vs divisor.
  function automatic exp_t model(input logic [31:0] a, b, input logic s, r);
    exp_t e;
    logic [63:0] am, bm, num, quo, rem, lim;
    logic neg;
    neg = s & (a[31] ^ b[31]);
    am  = (s && a[31]) ? 64'(~a) + 64'd1 : 64'(a);
    bm  = (s && b[31]) ? 64'(~b) + 64'd1 : 64'(b);
    lim = !s ? 64'hFFFF_FFFF : (neg ? 64'h8000_0000 : 64'h7FFF_FFFF);
    if (b == 32'd0) begin
      e = '{q: lim[31:0], dbz: 1'b1, ovf: 1'b0};
    end else begin
      num = am << 29;
      quo = num / bm;
      rem = num % bm;
      if (r && ((2 * rem > bm) || (2 * rem == bm && quo[0]))) quo = quo + 64'd1;
      if (quo > lim) e = '{q: lim[31:0], dbz: 1'b0, ovf: 1'b1};
      else e = '{q: neg ? 32'(64'd0 - quo) : quo[31:0], dbz: 1'b0, ovf: 1'b0};
    end
    return e;
  endfunction

  task automatic op(input int d, input logic [31:0] a, b, input logic s, r,
                    input exp_t e, input int lat, input int hold);
    int cyc;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", 64'(ir[d]), 64'd1);
    iv[d] = 1'b1; av[d] = a; bv[d] = b; sv[d] = s; rv[d] = r;
    @(posedge clk); #1;
    iv[d] = 1'b0; av[d] = ~a; bv[d] = ~b; sv[d] = ~s; rv[d] = ~r;
    chk("in_ready_busy", 64'(ir[d]), 64'd0);
    cyc = 0;
    while (!ov[d] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (lat > 0) chk("latency", 64'(cyc), 64'(lat));
    else chk("timeout", 64'(cyc < 200), 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_q", 64'(qv[d]), 64'(e.q));
      chk("hold_rdy", 64'(ir[d]), 64'd0);
      chk("hold_vld", 64'(ov[d]), 64'd1);
      @(posedge clk); #1;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      chk("q", 64'(qv[d]), 64'(x.q));
      chk("dbz", 64'(dz[d]), 64'(x.dbz));
      chk("ovf", 64'(of[d]), 64'(x.ovf));
    end
    @(negedge clk);
    orv[d] = 1'b1;
    @(posedge clk); #1;
    orv[d] = 1'b0;
    chk("vld_drop", 64'(ov[d]), 64'd0);
    chk("rdy_back", 64'(ir[d]), 64'd1);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra, rb;
    logic rs, rr;
    for (int i = 0; i < 3; i++) begin av[i] = '0; bv[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_q", 64'(qv[0]), 64'd0);
    chk("rst_dbz", 64'(dz[0]), 64'd0);
    chk("rst_ovf", 64'(of[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    op(0, 32'h2000_0000, 32'h4000_0000, 1, 0, '{32'h1000_0000, 1'b0, 1'b0}, 64, 0);
    op(0, 32'hA000_0000, 32'h4000_0000, 1, 0, '{32'hD000_0000, 1'b0, 1'b0}, 64, 0);
    op(0, 32'h8000_0000, 32'h2000_0000, 1, 0, '{32'h8000_0000, 1'b0, 1'b0}, 64, 0);
    op(0, 32'h6000_0000, 32'h0800_0000, 1, 0, '{32'h7FFF_FFFF, 1'b0, 1'b1}, 64, 0);
    op(1, 32'h6000_0000, 32'h0800_0000, 1, 0, '{32'h0000_0000, 1'b0, 1'b1}, 64, 0);
    op(0, 32'h0000_0001, 32'h4000_0000, 1, 0, '{32'h0, 1'b0, 1'b0}, 64, 0);
    op(0, 32'h0000_0001, 32'h4000_0000, 1, 1, '{32'h0, 1'b0, 1'b0}, 64, 0);
    op(0, 32'h0000_0003, 32'h4000_0000, 1, 0, '{32'h1, 1'b0, 1'b0}, 64, 0);
    op(0, 32'h0000_0003, 32'h4000_0000, 1, 1, '{32'h2, 1'b0, 1'b0}, 64, 0);
    op(0, 32'hE000_0000, 32'h0, 1, 0, '{32'h8000_0000, 1'b1, 1'b0}, 1, 0);
    op(0, 32'hE000_0000, 32'h0, 0, 0, '{32'hFFFF_FFFF, 1'b1, 1'b0}, 1, 0);
    op(1, 32'hE000_0000, 32'h0, 1, 0, '{32'h0, 1'b1, 1'b0}, 1, 0);
    op(2, 32'h2000_0000, 32'h4000_0000, 1, 0, '{32'h1000_0000, 1'b0, 1'b0}, 33, 5);
    op(2, 32'h0000_0003, 32'h4000_0000, 1, 1, '{32'h2, 1'b0, 1'b0}, 33, 0);

    for (int k = 0; k < 8; k++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 20);
      rs = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      op(0, ra, rb, rs, rr, model(ra, rb, rs, rr), 0, 0);
    end

    // Reset in the middle of CALC on the STEPS=2 instance.
    @(negedge clk);
    iv[2] = 1'b1; av[2] = 32'h2000_0000; bv[2] = 32'h4000_0000; sv[2] = 1'b1; rv[2] = 1'b0;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_calc_vld", 64'(ov[2]), 64'd0);
    chk("rst_calc_rdy", 64'(ir[2]), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is waiting: out_valid must drop at once.
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 32'h2000_0000; bv[0] = 32'h4000_0000; sv[0] = 1'b1; rv[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    cyc = 0;
    while (!ov[0] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_rst_vld", 64'(ov[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_vld", 64'(ov[0]), 64'd0);
    chk("rst_out_rdy", 64'(ir[0]), 64'd1);
    chk("rst_out_q", 64'(qv[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
